palette_writer: RTL
===================

// Module: palette_writer
// PURPOSE
//   Runtime writer for the 8-entry RGB palette; the palette becomes writable rather than fixed at build time.
//   Accepts a byte stream over a valid/ready port, assembles {R,G,B} entries into a shadow bank and
//   commits shadow->active on the next vblank rising edge, so the visible frame never tears.
//   Sits between the host/input pins and the pixel pipeline; active bank is read combinationally by color index.
// PARAMETERS
//   NCOLORS  8   palette entries (power of 2); IW = log2(NCOLORS) = 3
//   CW       6   bits per colour component
// PORTS
//   clk        in   1      pixel clock; single clock domain
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      byte on in_data is valid
//   in_data    in   8      stream byte
//   in_ready   out  1      byte accepted when in_valid && in_ready
//   vblank     in   1      level, high during vertical blanking
//   color      in   IW     read index from pixel pipeline
//   r, g, b    out  CW     active[color] components, combinational (0-cycle read)
//   pending    out  1      shadow differs from active (dirty), commit awaiting vblank
// BEHAVIOUR
// - Stream format: header byte has in_data[7]=1 and selects index = in_data[IW-1:0]
//   (bits 6:IW ignored). Data byte has in_data[7]=0; component = in_data[CW-1:0].
// - FSM: IDLE -> (header) R; R -(data)-> G; G -(data)-> B; B -(data)-> R with index+1 (mod NCOLORS).
//   A header in any state loads the index and goes to R, dropping partial R/G holds.
//   A data byte in IDLE is discarded.
// - R and G are held in registers. The shadow entry is written (all 3 fields at once) only on the
//   B-byte accept cycle; it is visible in shadow on the next cycle. Setting dirty is part of the same write.
// - Auto-increment wraps 7->0. Streaming 24 data bytes after header 0x80 rewrites the whole palette.
// - Commit: vblank_q is vblank registered; rise = vblank && !vblank_q.
//   The commit cycle is the cycle where rise && dirty. On it: active <= shadow (all entries, one cycle),
//   dirty <= 0, in_ready = 0.
//   in_ready = !(rise && dirty), combinational; otherwise 1.
//   A byte offered on the commit cycle is held by the source and accepted on the next cycle.
//   Entries completed while vblank is already high wait for the next rise (one commit per frame).
//   A rise with dirty=0 does nothing.
// - r/g/b follow active[color] combinationally. They change only on commit cycles or when color changes.
// - Reset (any time, including mid-entry or on a commit cycle):
//   state=IDLE, index=0, R/G holds=0, dirty=0, vblank_q=0.
//   Both banks = default grey ramp: entry i has r=g=b = i*9 (0,9,18,...,63).
//   Outputs after reset: pending=0, in_ready=1, r/g/b = color*9.
// - Widths: index is IW bits and wraps naturally. Components are truncated to CW bits; no saturation.
// STRUCTURE
// - Shared package palette_pkg: NCOLORS, CW, IW, FSM state enum {IDLE,R,G,B},
//   default-ramp constant/function (i*9), header-bit position constant.
// - One sub-module palette_bank: NCOLORS x 3*CW register file with 1 write port (idx, rgb, we),
//   bulk-load input (load, shadow contents) and combinational read port. Instantiated twice (shadow, active).
// - Top holds FSM, R/G holds, index counter, vblank edge detect, dirty flag.
// TESTING
// - Reset: assert rst 1 cycle -> pending=0, in_ready=1; sweep color 0..7 -> r=g=b=0,9,...,63.
// - Single entry: bytes 0x83,0x3F,0x00,0x15 with vblank=0 -> pending=1 after 4th byte,
//   r/g/b at color=3 still 27; raise vblank -> commit cycle has in_ready=0,
//   next cycle color=3 gives r=63,g=0,b=21, pending=0.
// - Auto-increment/wrap: header 0x87 then 6 data bytes (1,2,3,4,5,6) -> after commit entry7=(1,2,3), entry0=(4,5,6).
// - Abort/discard: data 0x11 in IDLE is ignored; 0x82,0x05,0x06 then 0x84,0x01,0x02,0x03
//   -> entry2 unchanged (18), entry4=(1,2,3).
// - Commit collision: complete an entry, then hold in_valid with 0x90 across a vblank rise
//   -> in_ready=0 exactly 1 cycle, byte accepted the following cycle, no byte lost or duplicated.
// - Reset mid-operation: rst after 0x81,0x3F (and separately on a commit cycle)
//   -> default ramp restored, pending=0; a following data byte is discarded (state IDLE).

Source files
------------

// File: rtl/palette_pkg.sv
// Shared constants, types and reset-content helper for the runtime palette writer.
package palette_pkg;

    localparam int NCOLORS = 8;
    localparam int IW      = 3;
    localparam int CW      = 6;
    localparam int EW      = 3 * CW;
    localparam int HDR_BIT = 7;

    // Stream assembly state: waiting for a header, or expecting the R/G/B byte.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        R    = 2'd1,
        G    = 2'd2,
        B    = 2'd3
    } state_t;

    // One palette entry packed as {r, g, b}.
    typedef logic [EW-1:0] entry_t;
    typedef logic [NCOLORS-1:0][EW-1:0] bank_t;

    // Grey-ramp reset contents: entry i has r = g = b = i*9 (0..63).
    function automatic entry_t default_entry(input logic [IW-1:0] i);
        logic [CW-1:0] ext;
        logic [CW-1:0] c;
        ext = CW'(i);
        c   = ext * 6'd9;
        return {c, c, c};
    endfunction

endpackage

// File: rtl/palette_bank.sv
// NCOLORS x {r,g,b} register file: one write port, a one-cycle bulk load
// of a whole bank image, and a combinational read port.
module palette_bank
    import palette_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  entry_t        wdata,
    input  logic          load,
    input  bank_t         load_data,
    input  logic [IW-1:0] ridx,
    output entry_t        rdata,
    output bank_t         contents
);

    bank_t mem_r;

    // Storage update: reset to grey ramp, bulk load wins over a single-entry write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCOLORS; i++) begin
                mem_r[i] <= default_entry(IW'(i));
            end
        end else if (load) begin
            mem_r <= load_data;
        end else if (we) begin
            mem_r[widx] <= wdata;
        end
    end

    // Zero-latency read for the pixel pipeline and full-image export for bulk copy.
    always_comb begin
        rdata    = mem_r[ridx];
        contents = mem_r;
    end

endmodule

// File: rtl/palette_writer.sv
// Runtime palette writer: assembles {R,G,B} entries from a byte stream into a
// shadow bank and copies shadow to the active bank on a vblank rising edge,
// so the visible frame never sees a half-updated palette.
module palette_writer
    import palette_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          vblank,
    input  logic [IW-1:0] color,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          pending
);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_nxt_s;
    logic [CW-1:0] r_hold_r;
    logic [CW-1:0] r_hold_nxt_s;
    logic [CW-1:0] g_hold_r;
    logic [CW-1:0] g_hold_nxt_s;
    logic          dirty_r;
    logic          vblank_q_r;

    logic          rise_s;
    logic          commit_s;
    logic          accept_s;
    logic          is_hdr_s;
    logic          shadow_we_s;
    entry_t        shadow_wdata_s;
    bank_t         shadow_image_s;
    entry_t        active_rdata_s;

    // Commit handshake: the commit cycle stalls the stream so no byte races the copy.
    always_comb begin
        rise_s         = vblank & ~vblank_q_r;
        commit_s       = rise_s & dirty_r;
        in_ready       = ~commit_s;
        accept_s       = in_valid & ~commit_s;
        is_hdr_s       = in_data[HDR_BIT];
        shadow_wdata_s = {r_hold_r, g_hold_r, in_data[CW-1:0]};
        pending        = dirty_r;
    end

    // Stream FSM next-state: headers restart at R, B bytes write shadow and advance the index.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        r_hold_nxt_s = r_hold_r;
        g_hold_nxt_s = g_hold_r;
        shadow_we_s  = 1'b0;
        if (accept_s) begin
            if (is_hdr_s) begin
                idx_nxt_s    = in_data[IW-1:0];
                state_nxt_s  = R;
                r_hold_nxt_s = '0;
                g_hold_nxt_s = '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_nxt_s = IDLE;
                    end
                    R: begin
                        r_hold_nxt_s = in_data[CW-1:0];
                        state_nxt_s  = G;
                    end
                    G: begin
                        g_hold_nxt_s = in_data[CW-1:0];
                        state_nxt_s  = B;
                    end
                    B: begin
                        shadow_we_s = 1'b1;
                        idx_nxt_s   = idx_r + 3'd1;
                        state_nxt_s = R;
                    end
                    default: begin
                        state_nxt_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, index and component-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            r_hold_r <= '0;
            g_hold_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            idx_r    <= idx_nxt_s;
            r_hold_r <= r_hold_nxt_s;
            g_hold_r <= g_hold_nxt_s;
        end
    end

    // vblank edge detect and dirty flag; a commit and a shadow write never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q_r <= 1'b0;
            dirty_r    <= 1'b0;
        end else begin
            vblank_q_r <= vblank;
            if (commit_s) begin
                dirty_r <= 1'b0;
            end else if (shadow_we_s) begin
                dirty_r <= 1'b1;
            end
        end
    end

    palette_bank u_shadow (
        .clk       (clk),
        .rst       (rst),
        .we        (shadow_we_s),
        .widx      (idx_r),
        .wdata     (shadow_wdata_s),
        .load      (1'b0),
        .load_data ('0),
        .ridx      (color),
        .rdata     (),
        .contents  (shadow_image_s)
    );

    palette_bank u_active (
        .clk       (clk),
        .rst       (rst),
        .we        (1'b0),
        .widx      ('0),
        .wdata     ('0),
        .load      (commit_s),
        .load_data (shadow_image_s),
        .ridx      (color),
        .rdata     (active_rdata_s),
        .contents  ()
    );

    // Split the active entry into its visible components.
    always_comb begin
        r = active_rdata_s[3*CW-1:2*CW];
        g = active_rdata_s[2*CW-1:CW];
        b = active_rdata_s[CW-1:0];
    end

endmodule
